// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: scancode constants, receiver state encoding
// and the frame parity rule.
package ps2_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SC_BREAK = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_R     = 8'h2D;
    localparam logic [BYTE_W-1:0] SC_G     = 8'h34;
    localparam logic [BYTE_W-1:0] SC_B     = 8'h32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic parity_ok(input logic [BYTE_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock and emits a one-cycle
// strobe on each filtered falling edge. Receive-only; reusable by a transmitter.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        cnt_d       = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    assign data_sync = data_sync_q[1];
    assign fall      = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames into scancodes and
// optionally swallows break (release) sequences so only presses raise flag.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN   = 8,
    parameter int unsigned TIMEOUT_CYC  = 5000,
    parameter bit          FILTER_BREAK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] scancode,
    output logic              flag,
    output logic              frame_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic fall;
    logic data_s;

    ps2_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              break_pend_q, break_pend_d;
    logic [BYTE_W-1:0] scancode_q, scancode_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_sync (data_s),
        .fall      (fall)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            break_pend_q <= 1'b0;
            scancode_q   <= '0;
            flag_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            break_pend_q <= break_pend_d;
            scancode_q   <= scancode_d;
            flag_q       <= flag_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        break_pend_d = break_pend_q;
        scancode_d   = scancode_q;
        flag_d       = 1'b0;
        err_d        = 1'b0;

        // Saturating mid-frame watchdog; any fall restarts it.
        if (fall || state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT_CYC)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {data_s, shreg_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (parity_ok(shreg_q, par_q) && data_s) begin
                        if (FILTER_BREAK && shreg_q == SC_BREAK) begin
                            break_pend_d = 1'b1;
                        end else if (FILTER_BREAK && break_pend_q) begin
                            break_pend_d = 1'b0;
                        end else begin
                            scancode_d = shreg_q;
                            flag_d     = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC)) begin
            state_d = IDLE;
        end
    end

    assign scancode  = scancode_q;
    assign flag      = flag_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench: two receivers (break filtering on and off) share the same
// PS/2 lines; expected scancodes are queued per receiver and popped on flag.
module tb_ps2_scancode_rx;

    localparam int unsigned HALF = 30;
    localparam int unsigned TMO  = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] sc1, sc0;
    logic       fl1, fl0, er1, er0;

    int checks   = 0;
    int failures = 0;
    int err1     = 0;
    int err0     = 0;
    int exp_err  = 0;
    logic [7:0] q1[$];
    logic [7:0] q0[$];
    logic fl1_prev = 1'b0;
    logic fl0_prev = 1'b0;

    always #5 clk = ~clk;

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .FILTER_BREAK(1'b1)) u_fb1 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(sc1), .flag(fl1), .frame_err(er1)
    );

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .FILTER_BREAK(1'b0)) u_fb0 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(sc0), .flag(fl0), .frame_err(er0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every flag, count frame errors.
    always @(negedge clk) begin
        if (reset) begin
            if (fl1) begin
                check("fb1_flag_width", 32'(fl1_prev), 32'd0);
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fb1_unexpected_flag actual=%0h expected=none", sc1);
                end else begin
                    logic [7:0] e1;
                    e1 = q1.pop_front();
                    check("fb1_scancode", 32'(sc1), 32'(e1));
                end
            end
            if (fl0) begin
                check("fb0_flag_width", 32'(fl0_prev), 32'd0);
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fb0_unexpected_flag actual=%0h expected=none", sc0);
                end else begin
                    logic [7:0] e0;
                    e0 = q0.pop_front();
                    check("fb0_scancode", 32'(sc0), 32'(e0));
                end
            end
            if (er1) err1++;
            if (er0) err0++;
        end
        fl1_prev = fl1;
        fl0_prev = fl0;
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 13);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Sends start + first nbits data bits; nbits==8 also sends parity and stop.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < nbits; i++) send_bit(b[i], glitch);
        if (nbits == 8) begin
            send_bit(par, glitch);
            send_bit(1'b1, glitch);
        end
        ps2_data = 1'b1;
        wait_cyc(4 * HALF);
    endtask

    task automatic check_drained(input string name);
        check({name, "_fb1_pending"}, 32'(q1.size()), 32'd0);
        check({name, "_fb0_pending"}, 32'(q0.size()), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check("rst_sc1", 32'(sc1), 32'h00);
        check("rst_sc0", 32'(sc0), 32'h00);
        check("rst_flag", 32'({fl1, fl0}), 32'd0);
        check("rst_err", 32'({er1, er0}), 32'd0);
        reset = 1'b1;
        wait_cyc(20);

        // Single R key frame
        q1.push_back(8'h2D); q0.push_back(8'h2D);
        send_frame(8'h2D, 1'b0, 1'b0, 8);
        check_drained("r_key");

        // Press, break prefix, release
        q1.push_back(8'h34);
        q0.push_back(8'h34); q0.push_back(8'hF0); q0.push_back(8'h34);
        send_frame(8'h34, 1'b0, 1'b0, 8);
        send_frame(8'hF0, 1'b0, 1'b0, 8);
        send_frame(8'h34, 1'b0, 1'b0, 8);
        check_drained("break_seq");
        check("break_sc1_hold", 32'(sc1), 32'h34);
        check("break_sc0_last", 32'(sc0), 32'h34);

        // Bad parity then good frame
        exp_err++;
        send_frame(8'h32, 1'b1, 1'b0, 8);
        check("par_err_fb1", 32'(err1), 32'(exp_err));
        check("par_err_fb0", 32'(err0), 32'(exp_err));
        check("par_sc1_hold", 32'(sc1), 32'h34);
        check("par_sc0_hold", 32'(sc0), 32'h34);
        check_drained("par_bad");
        q1.push_back(8'h32); q0.push_back(8'h32);
        send_frame(8'h32, 1'b0, 1'b0, 8);
        check_drained("par_good");

        // Short clock glitches between bits
        q1.push_back(8'h2D); q0.push_back(8'h2D);
        send_frame(8'h2D, 1'b0, 1'b1, 8);
        check_drained("glitch");

        // Truncated frame abandoned by timeout
        send_frame(8'h2D, 1'b0, 1'b0, 4);
        wait_cyc(TMO + 100);
        check_drained("tmo_partial");
        q1.push_back(8'h2D); q0.push_back(8'h2D);
        send_frame(8'h2D, 1'b0, 1'b0, 8);
        check_drained("tmo_recover");

        // Reset after the 5th data bit, then the rest of the aborted frame
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(8'h34 >> i), 1'b0);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        check("midrst_sc1", 32'(sc1), 32'h00);
        check("midrst_sc0", 32'(sc0), 32'h00);
        for (int i = 5; i < 8; i++) send_bit(1'(8'h34 >> i), 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(TMO + 100);
        check_drained("midrst_tail");
        check("midrst_sc1_after", 32'(sc1), 32'h00);
        q1.push_back(8'h32); q0.push_back(8'h32);
        send_frame(8'h32, 1'b0, 1'b0, 8);
        check_drained("midrst_next");

        check("total_err_fb1", 32'(err1), 32'(exp_err));
        check("total_err_fb0", 32'(err0), 32'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
